// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes, ALU controls
// and the datapath mux select encodings.
package cpu_pkg;

  // FSM state encodings (plain constants so legacy tools can consume them)
  localparam logic [3:0] StFetch    = 4'd0;
  localparam logic [3:0] StDecode   = 4'd1;
  localparam logic [3:0] StMemAdr   = 4'd2;
  localparam logic [3:0] StMemRead  = 4'd3;
  localparam logic [3:0] StMemWb    = 4'd4;
  localparam logic [3:0] StMemWrite = 4'd5;
  localparam logic [3:0] StExecR    = 4'd6;
  localparam logic [3:0] StExecI    = 4'd7;
  localparam logic [3:0] StAluWb    = 4'd8;
  localparam logic [3:0] StBeq      = 4'd9;
  localparam logic [3:0] StJal      = 4'd10;

  // Opcodes
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // ALU control codes
  localparam logic [2:0] AluAdd     = 3'b000;
  localparam logic [2:0] AluSub     = 3'b001;
  localparam logic [2:0] AluAnd     = 3'b010;
  localparam logic [2:0] AluOr      = 3'b011;
  localparam logic [2:0] AluSlt     = 3'b101;
  localparam logic [2:0] AluInvalid = 3'b111;

  typedef enum logic [1:0] {
    AluOpAdd  = 2'b00,
    AluOpSub  = 2'b01,
    AluOpFunc = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    ResAluOut    = 2'b00,
    ResReadData  = 2'b01,
    ResAluResult = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SrcAPc    = 2'b00,
    SrcAOldPc = 2'b01,
    SrcARs1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SrcBRs2  = 2'b00,
    SrcBImm  = 2'b01,
    SrcBFour = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ImmI = 2'b00,
    ImmS = 2'b01,
    ImmB = 2'b10,
    ImmJ = 2'b11
  } imm_src_e;

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath/memory signal bundle. The controller is the master.
interface multicycle_control_if;
  import cpu_pkg::*;

  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic        alu_zero;
  logic        mem_ready;
  logic        pc_write;
  logic        adr_src;
  logic        ir_write;
  logic        mem_write;
  logic        reg_write;
  result_src_e result_src;
  alu_src_a_e  alu_src_a;
  alu_src_b_e  alu_src_b;
  imm_src_e    imm_source;
  logic [2:0]  alu_control;
  logic        illegal_instr;
  logic        instr_done;

  modport master (
    input  op, func3, func7, alu_zero, mem_ready,
    output pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_source, alu_control, illegal_instr, instr_done
  );

  modport slave (
    output op, func3, func7, alu_zero, mem_ready,
    input  pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_source, alu_control, illegal_instr, instr_done
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the main FSM's alu_op plus instruction fields to an ALU control code.
module alu_decoder
  import cpu_pkg::*;
(
  input  alu_op_e    alu_op_i,
  input  logic [2:0] func3_i,
  input  logic       func7_5_i,
  input  logic       op_5_i,
  output logic [2:0] alu_control_o
);

  // Decode; op[5] separates R-type (sub possible) from I-type (addi only)
  always_comb begin
    alu_control_o = AluInvalid;
    case (alu_op_i)
      AluOpAdd: alu_control_o = AluAdd;
      AluOpSub: alu_control_o = AluSub;
      AluOpFunc: begin
        case (func3_i)
          3'b000:  alu_control_o = (op_5_i && func7_5_i) ? AluSub : AluAdd;
          3'b010:  alu_control_o = AluSlt;
          3'b110:  alu_control_o = AluOr;
          3'b111:  alu_control_o = AluAnd;
          default: alu_control_o = AluInvalid;
        endcase
      end
      default: alu_control_o = AluInvalid;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: fetch/decode/execute/memory/writeback sequencing
// for lw, sw, R-type, I-type ALU, beq and jal with a memory ready handshake.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter bit SUPPORT_JAL    = 1'b1,
  parameter bit SUPPORT_ITYPE  = 1'b1,
  parameter bit WAIT_STATES_EN = 1'b1
) (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_if.master ctrl_io
);

  logic [3:0]  state_q, state_d;
  logic        ready;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write, illegal, done;
  result_src_e result_src;
  alu_src_a_e  alu_src_a;
  alu_src_b_e  alu_src_b;
  alu_op_e     alu_op;
  imm_src_e    imm_source;

  assign ready = WAIT_STATES_EN ? ctrl_io.mem_ready : 1'b1;

  // Only func7[5] matters for decoding
  logic unused_func7;
  assign unused_func7 = ^{ctrl_io.func7[6], ctrl_io.func7[4:0]};

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    done       = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRs2;
    alu_op     = AluOpAdd;
    case (state_q)
      StFetch: begin
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        ir_write   = ready;
        pc_write   = ready;
        state_d    = ready ? StDecode : StFetch;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        if (ctrl_io.op == OpLoad || ctrl_io.op == OpStore) begin
          state_d = StMemAdr;
        end else if (ctrl_io.op == OpRtype) begin
          state_d = StExecR;
        end else if (SUPPORT_ITYPE && ctrl_io.op == OpItype) begin
          state_d = StExecI;
        end else if (ctrl_io.op == OpBranch) begin
          state_d = StBeq;
        end else if (SUPPORT_JAL && ctrl_io.op == OpJal) begin
          state_d = StJal;
        end else begin
          // PC already advanced in fetch, so the instruction is simply skipped
          illegal = 1'b1;
          done    = 1'b1;
          state_d = StFetch;
        end
      end
      StMemAdr: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        state_d   = (ctrl_io.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = ready ? StMemWb : StMemRead;
      end
      StMemWb: begin
        result_src = ResReadData;
        reg_write  = 1'b1;
        done       = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        done      = ready;
        state_d   = ready ? StFetch : StMemWrite;
      end
      StExecR: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpFunc;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = SrcARs1;
        alu_src_b = SrcBImm;
        alu_op    = AluOpFunc;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      StBeq: begin
        alu_src_a = SrcARs1;
        alu_op    = AluOpSub;
        done      = 1'b1;
        if (ctrl_io.func3 == 3'b000) pc_write = ctrl_io.alu_zero;
        else                         illegal  = 1'b1;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      default: state_d = StFetch;
    endcase
    // No architectural side effects while reset is held
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
      done      = 1'b0;
    end
  end

  // Immediate format follows the opcode in every state
  always_comb begin
    case (ctrl_io.op)
      OpStore:  imm_source = ImmS;
      OpBranch: imm_source = ImmB;
      OpJal:    imm_source = ImmJ;
      default:  imm_source = ImmI;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .func3_i       (ctrl_io.func3),
    .func7_5_i     (ctrl_io.func7[5]),
    .op_5_i        (ctrl_io.op[5]),
    .alu_control_o (ctrl_io.alu_control)
  );

  assign ctrl_io.pc_write      = pc_write;
  assign ctrl_io.adr_src       = adr_src;
  assign ctrl_io.ir_write      = ir_write;
  assign ctrl_io.mem_write     = mem_write;
  assign ctrl_io.reg_write     = reg_write;
  assign ctrl_io.result_src    = result_src;
  assign ctrl_io.alu_src_a     = alu_src_a;
  assign ctrl_io.alu_src_b     = alu_src_b;
  assign ctrl_io.imm_source    = imm_source;
  assign ctrl_io.illegal_instr = illegal;
  assign ctrl_io.instr_done    = done;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Strobe vectors are packed as
// {pc_write, ir_write, mem_write, reg_write, illegal_instr, instr_done}.
module tb_multicycle_control;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  multicycle_control_if bus_a ();
  multicycle_control_if bus_b ();

  // Full-featured controller with wait states
  multicycle_control #(
    .SUPPORT_JAL    (1'b1),
    .SUPPORT_ITYPE  (1'b1),
    .WAIT_STATES_EN (1'b1)
  ) u_dut_a (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus_a)
  );

  // Reduced controller: no jal, no I-type, mem_ready ignored
  multicycle_control #(
    .SUPPORT_JAL    (1'b0),
    .SUPPORT_ITYPE  (1'b0),
    .WAIT_STATES_EN (1'b0)
  ) u_dut_b (
    .clk     (clk),
    .rst     (rst),
    .ctrl_io (bus_b)
  );

  logic [5:0] strb_a, strb_b;
  assign strb_a = {bus_a.pc_write, bus_a.ir_write, bus_a.mem_write, bus_a.reg_write,
                   bus_a.illegal_instr, bus_a.instr_done};
  assign strb_b = {bus_b.pc_write, bus_b.ir_write, bus_b.mem_write, bus_b.reg_write,
                   bus_b.illegal_instr, bus_b.instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic zero, input logic ready);
    bus_a.op = op;  bus_a.func3 = f3;  bus_a.func7 = f7;
    bus_a.alu_zero = zero;  bus_a.mem_ready = ready;
    bus_b.op = op;  bus_b.func3 = f3;  bus_b.func7 = f7;
    bus_b.alu_zero = zero;  bus_b.mem_ready = ready;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Check DUT A strobes for the current state, then advance one clock
  task automatic step(input string tag, input logic [5:0] exp);
    chk(tag, 32'(strb_a), 32'(exp));
    next_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  // One ALU instruction on DUT A: fetch, decode, execute (check alu_control), writeback
  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [2:0] exp_ctl);
    drive(op, f3, f7, 1'b0, 1'b1);
    step({tag, " fetch"}, 6'b110000);
    step({tag, " decode"}, 6'b000000);
    chk({tag, " alu_control"}, 32'(bus_a.alu_control), 32'(exp_ctl));
    step({tag, " exec"}, 6'b000000);
    chk({tag, " wb result_src"}, 32'(bus_a.result_src), 32'd0);
    step({tag, " wb"}, 6'b000101);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    drive(7'b0000011, 3'b010, 7'd0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset strobes a", 32'(strb_a), 32'd0);
    chk("reset strobes b", 32'(strb_b), 32'd0);
    rst = 1'b0;
    #1;

    // lw: FETCH, DECODE, MEMADR, MEMREAD, MEMWB
    chk("lw fetch alu_src_b", 32'(bus_a.alu_src_b), 32'd2);
    chk("lw fetch result_src", 32'(bus_a.result_src), 32'd2);
    chk("lw fetch alu_control", 32'(bus_a.alu_control), 32'd0);
    chk("lw imm_source", 32'(bus_a.imm_source), 32'd0);
    step("lw fetch", 6'b110000);
    chk("lw decode alu_src_a", 32'(bus_a.alu_src_a), 32'd1);
    chk("lw decode alu_src_b", 32'(bus_a.alu_src_b), 32'd1);
    step("lw decode", 6'b000000);
    chk("lw memadr alu_src_a", 32'(bus_a.alu_src_a), 32'd2);
    step("lw memadr", 6'b000000);
    chk("lw memread adr_src", 32'(bus_a.adr_src), 32'd1);
    step("lw memread", 6'b000000);
    chk("lw memwb result_src", 32'(bus_a.result_src), 32'd1);
    step("lw memwb", 6'b000101);

    // sw with three wait cycles in MEMWRITE
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1);
    chk("sw imm_source", 32'(bus_a.imm_source), 32'd1);
    step("sw fetch", 6'b110000);
    step("sw decode", 6'b000000);
    step("sw memadr", 6'b000000);
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("sw wait adr_src", 32'(bus_a.adr_src), 32'd1);
      step("sw wait", 6'b001000);
    end
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1);
    chk("sw done adr_src", 32'(bus_a.adr_src), 32'd1);
    step("sw done", 6'b001001);

    // R-type and I-type ALU decode
    run_alu("r sub", 7'b0110011, 3'b000, 7'b0100000, 3'b001);
    run_alu("r add", 7'b0110011, 3'b000, 7'b0000000, 3'b000);
    run_alu("r or", 7'b0110011, 3'b110, 7'b0000000, 3'b011);
    run_alu("r sltu", 7'b0110011, 3'b011, 7'b0000000, 3'b111);
    run_alu("i addi", 7'b0010011, 3'b000, 7'b0100000, 3'b000);
    run_alu("i slti", 7'b0010011, 3'b010, 7'b0000000, 3'b101);
    run_alu("i andi", 7'b0010011, 3'b111, 7'b0000000, 3'b010);

    // beq taken / not taken / bad func3
    drive(7'b1100011, 3'b000, 7'd0, 1'b1, 1'b1);
    chk("beq imm_source", 32'(bus_a.imm_source), 32'd2);
    step("beq1 fetch", 6'b110000);
    step("beq1 decode", 6'b000000);
    chk("beq alu_control", 32'(bus_a.alu_control), 32'd1);
    step("beq taken", 6'b100001);
    drive(7'b1100011, 3'b000, 7'd0, 1'b0, 1'b1);
    step("beq2 fetch", 6'b110000);
    step("beq2 decode", 6'b000000);
    step("beq not taken", 6'b000001);
    drive(7'b1100011, 3'b001, 7'd0, 1'b1, 1'b1);
    step("beq3 fetch", 6'b110000);
    step("beq3 decode", 6'b000000);
    step("beq bad func3", 6'b000011);

    // Illegal opcode
    drive(7'b1111111, 3'b000, 7'd0, 1'b0, 1'b1);
    step("ill fetch", 6'b110000);
    step("ill decode", 6'b000011);
    step("ill next fetch", 6'b110000);

    // jal: legal on A, illegal on B; B ignores mem_ready
    do_reset();
    drive(7'b1101111, 3'b000, 7'd0, 1'b0, 1'b0);
    chk("jal fetch stall a", 32'(strb_a), 32'd0);
    chk("nowait fetch b", 32'(strb_b), 32'(6'b110000));
    next_cycle();
    drive(7'b1101111, 3'b000, 7'd0, 1'b0, 1'b1);
    chk("jal imm_source", 32'(bus_a.imm_source), 32'd3);
    chk("jal fetch a", 32'(strb_a), 32'(6'b110000));
    chk("jal illegal decode b", 32'(strb_b), 32'(6'b000011));
    next_cycle();
    chk("jal decode a", 32'(strb_a), 32'd0);
    chk("jal refetch b", 32'(strb_b), 32'(6'b110000));
    next_cycle();
    chk("jal alu_src_a", 32'(bus_a.alu_src_a), 32'd1);
    chk("jal alu_src_b", 32'(bus_a.alu_src_b), 32'd2);
    step("jal state", 6'b100000);
    step("jal aluwb", 6'b000101);

    // I-type unsupported on B
    do_reset();
    drive(7'b0010011, 3'b000, 7'd0, 1'b0, 1'b1);
    next_cycle();
    chk("itype illegal decode b", 32'(strb_b), 32'(6'b000011));
    chk("itype decode a", 32'(strb_a), 32'd0);

    // Reset asserted while sw is stalled in MEMWRITE
    do_reset();
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1);
    step("rsw fetch", 6'b110000);
    step("rsw decode", 6'b000000);
    step("rsw memadr", 6'b000000);
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    chk("rsw memwrite", 32'(strb_a), 32'(6'b001000));
    rst = 1'b1;
    #1;
    chk("rsw reset gated", 32'(strb_a), 32'd0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rsw fetch waiting", 32'(strb_a), 32'd0);
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b1);
    chk("rsw fetch ready", 32'(strb_a), 32'(6'b110000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main/ALU decoder.
- FSM sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Waits on a memory ready handshake.
- Sits between the shared instruction/data memory port and the datapath muxes/enables of the multi-cycle core.

Parameters:
- SUPPORT_JAL, 1, 0 makes jal illegal.
- SUPPORT_ITYPE, 1, 0 makes opcode 0010011 illegal.
- WAIT_STATES_EN, 1, 0 ignores mem_ready (treated as constant 1).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- op  in  7  opcode from instruction register.
- func3  in  3  instr[14:12].
- func7  in  7  instr[31:25].
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes read/write this cycle.
- pc_write  out  1  PC register enable.
- adr_src  out  1  0: address = PC; 1: address = ALUOut.
- ir_write  out  1  instruction register and old-PC enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register file write enable.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- imm_source  out  2  00 I, 01 S, 10 B, 11 J.
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 invalid.
- illegal_instr  out  1  one-cycle pulse on unsupported opcode.
- instr_done  out  1  one-cycle pulse in the last state of each instruction.

Behaviour:
- State register is clocked. All outputs are combinational from state, op, func3, func7, alu_zero and mem_ready.
- Unlisted outputs are 0 in each state.
- Reset: state <= FETCH. While rst=1, pc_write, ir_write, mem_write, reg_write, illegal_instr and instr_done are forced 0.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Stays in FETCH until mem_ready, then DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch/jump target). Next state by op:
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - else -> illegal_instr=1, instr_done=1, next FETCH (instruction skipped; PC already advanced).
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src=1, result_src=00. Stays until mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, instr_done=1, next FETCH.
- MEMWRITE:
  - adr_src=1, result_src=00, mem_write=1, held every cycle until mem_ready.
  - On mem_ready: instr_done=1, next FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10, next ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10, next ALUWB.
- ALUWB: result_src=00, reg_write=1, instr_done=1, next FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write=alu_zero; instr_done=1; next FETCH.
  - func3 != 000 is illegal: pulse illegal_instr, pc_write=0.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1, next ALUWB (rd <- old PC+4).
- imm_source from op in every state: lw/I-type 00, sw 01, beq 10, jal 11, other 00.
- ALU decode:
  - alu_op 00 -> 000; alu_op 01 -> 001.
  - alu_op 10 by func3: 000 -> 001 if op=0110011 and func7[5]=1, else 000; 010 -> 101; 110 -> 011; 111 -> 010; other -> 111.
- With WAIT_STATES_EN=0, FETCH, MEMREAD and MEMWRITE take exactly one cycle.
- CPI: lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2 (zero wait states).
- Reset asserted mid-instruction: abort next edge and return to FETCH; no write enable is asserted during the reset cycle.
- Any unreachable state encoding -> FETCH.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL);
  - opcode constants;
  - alu_control constants;
  - alu_op, result_src, alu_src and imm_source encodings.
- One sub-module, alu_decoder (alu_op, func3, func7[5], op[5] -> alu_control), instantiated inside.

Test Plan:
- lw (op 0000011, func3 010), mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 only in cycle 5; instr_done pulse cycle 5.
- sw with mem_ready low 3 cycles in MEMWRITE -> mem_write=1 for 4 consecutive cycles, adr_src=1 throughout, FETCH follows; reg_write never 1.
- R-type func3 000, func7 0100000 -> alu_control=001 in EXECR; func7 0000000 -> 000; func3 110 -> 011; func3 011 -> 111.
- beq with alu_zero=1 -> pc_write=1 in BEQ; with alu_zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
- Illegal opcode 1111111, and jal with SUPPORT_JAL=0 -> illegal_instr pulse in DECODE, FETCH next, no reg_write/mem_write.
- rst=1 asserted in MEMWRITE while mem_write=1 -> mem_write 0 that cycle, state FETCH after release, first fetch ir_write=1 on mem_ready.
